ram_bwe: RTL and testbench

Parametrised single-port synchronous RAM. It is the next generation of the fixed 32x32 `ram` block (ena, wena, addr, data_in, data_out).
- Adds configurable width and depth, per-byte write enables, a registered read with a valid strobe, and a hardware clear engine.
- The clear engine zeroes the whole array after reset or on request.
- Used as a generic data/register store in the course CPU datapath.

---
 rtl/ram_bwe_pkg.sv | 18 +
 rtl/ram_bwe_clr_fsm.sv | 60 ++++++
 rtl/ram_bwe.sv | 139 +++++++++++++
 tb/tb_ram_bwe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bwe_pkg.sv
// Shared types and constants for the ram_bwe single-port RAM.
// The optional lane parity is enabled with the RAM_BWE_PARITY_EN macro.
package ram_bwe_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_BYTE_W = 8;

    function automatic int lane_count(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/ram_bwe_clr_fsm.sv
// Clear engine for ram_bwe: walks every address writing zero after reset
// or on clr_req, and holds busy while doing so.
module ram_bwe_clr_fsm
    import ram_bwe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    clr_state_t        state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              busy_r;

    // Clear sequencer: one address per cycle, re-armed by clr_req only when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            ptr_r   <= ZERO_ADDR;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (ptr_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= ZERO_ADDR;
                        busy_r  <= 1'b0;
                    end else begin
                        ptr_r   <= ptr_r + ADDR_W'(1'b1);
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= ZERO_ADDR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    ptr_r   <= ZERO_ADDR;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign clr_we   = (state_r == ST_CLEAR);
    assign clr_addr = ptr_r;

endmodule

// File: rtl/ram_bwe.sv
// Parametrised single-port RAM with byte enables, registered read and clear engine.
// Define RAM_BWE_PARITY_EN to add per-lane even parity and the parity_err output.
module ram_bwe
    import ram_bwe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYTE_W = DEF_BYTE_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ena,
    input  logic                                   wena,
    input  logic [lane_count(DATA_W, BYTE_W)-1:0]  be,
    input  logic [ADDR_W-1:0]                      addr,
    input  logic [DATA_W-1:0]                      data_in,
    input  logic                                   clr_req,
    output logic [DATA_W-1:0]                      data_out,
    output logic                                   rd_valid,
    output logic                                   busy
`ifdef RAM_BWE_PARITY_EN
    ,
    output logic                                   parity_err
`endif
);

    localparam int NB    = lane_count(DATA_W, BYTE_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] data_out_r;
    logic              rd_valid_r;

    logic              busy_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              clr_wr_s;
    logic              wr_s;
    logic              rd_s;

    ram_bwe_clr_fsm #(
        .ADDR_W   (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // Access qualification: clear engine and a fresh clr_req both pre-empt user accesses.
    always_comb begin
        clr_wr_s = 1'b0;
        wr_s     = 1'b0;
        rd_s     = 1'b0;
        if (rst) begin
            clr_wr_s = 1'b0;
        end else if (clr_we_s) begin
            clr_wr_s = 1'b1;
        end else if (ena && !clr_req) begin
            wr_s = wena;
            rd_s = !wena;
        end else begin
            wr_s = 1'b0;
            rd_s = 1'b0;
        end
    end

    // Array write port; contents are never reset, only zeroed by the clear engine.
    always_ff @(posedge clk) begin
        if (clr_wr_s) begin
            mem_r[clr_addr_s] <= {DATA_W{1'b0}};
        end else if (wr_s) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) begin
                    mem_r[addr][k*BYTE_W +: BYTE_W] <= data_in[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

`ifdef RAM_BWE_PARITY_EN
    logic [NB-1:0] par_r [DEPTH];
    logic          parity_err_r;

    function automatic logic [NB-1:0] lane_parity(input logic [DATA_W-1:0] word);
        logic [NB-1:0] p;
        for (int k = 0; k < NB; k++) begin
            p[k] = ^word[k*BYTE_W +: BYTE_W];
        end
        return p;
    endfunction

    // Parity side-array, updated lane-for-lane with the data array.
    always_ff @(posedge clk) begin
        if (clr_wr_s) begin
            par_r[clr_addr_s] <= {NB{1'b0}};
        end else if (wr_s) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) begin
                    par_r[addr][k] <= ^data_in[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Parity check registered alongside the read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_r <= 1'b0;
        end else if (rd_s) begin
            parity_err_r <= |(lane_parity(mem_r[addr]) ^ par_r[addr]);
        end else begin
            parity_err_r <= 1'b0;
        end
    end

    assign parity_err = parity_err_r;
`endif

    // Registered read port; data_out holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_s;
            if (rd_s) begin
                data_out_r <= mem_r[addr];
            end
        end
    end

    assign data_out = data_out_r;
    assign rd_valid = rd_valid_r;
    assign busy     = busy_s;

endmodule

// File: tb/tb_ram_bwe.sv
// Self-checking bench for ram_bwe: directed vector table, clear/reset sequences
// and randomized traffic against an array-level reference model.
module tb_ram_bwe;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        wena;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic        clr_req;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        busy;
`ifdef RAM_BWE_PARITY_EN
    logic        parity_err;
`endif

    ram_bwe dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wena       (wena),
        .be         (be),
        .addr       (addr),
        .data_in    (data_in),
        .clr_req    (clr_req),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .busy       (busy)
`ifdef RAM_BWE_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // reference model: whole-array view, clear modelled as a cycle countdown
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_dout;
    logic        m_rv;
    logic        m_perr;
    int          m_rem;
    int          flip_addr = -1;

    typedef struct {
        logic        e;
        logic        w;
        logic [3:0]  b;
        logic [4:0]  a;
        logic [31:0] d;
        logic        c;
        logic [31:0] xd;
        logic        xv;
        logic        xb;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_dout = 32'h0;
        m_rv   = 1'b0;
        m_perr = 1'b0;
        m_rem  = DEPTH;
    endtask

    task automatic model_step();
        m_perr = 1'b0;
        if (m_rem > 0) begin
            m_rem--;
            m_rv = 1'b0;
        end else if (clr_req) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            m_rem = DEPTH;
            m_rv  = 1'b0;
        end else if (ena && wena) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) m_mem[addr][k*8 +: 8] = data_in[k*8 +: 8];
            m_rv = 1'b0;
        end else if (ena) begin
            m_dout = m_mem[addr];
            m_rv   = 1'b1;
            m_perr = (flip_addr == int'(addr));
        end else begin
            m_rv = 1'b0;
        end
    endtask

    // one clock: drive at negedge, model at posedge, check 1 time unit later
    task automatic cycle(input logic e, input logic w, input logic [3:0] b,
                         input logic [4:0] a, input logic [31:0] d, input logic c);
        ena = e; wena = w; be = b; addr = a; data_in = d; clr_req = c;
        @(posedge clk);
        model_step();
        #1;
        check("data_out", data_out, m_dout);
        check("rd_valid", {31'h0, rd_valid}, {31'h0, m_rv});
        check("busy", {31'h0, busy}, {31'h0, (m_rem > 0)});
`ifdef RAM_BWE_PARITY_EN
        check("parity_err", {31'h0, parity_err}, {31'h0, m_perr});
`endif
        @(negedge clk);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b1, 4'hF, 5'b01010, 32'habcdef12, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 5'b01010, 32'h00000000, 1'b0, 32'habcdef12, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'hF, 5'b10101, 32'h12345678, 1'b0, 32'habcdef12, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'h5, 5'b10101, 32'hffffffff, 1'b0, 32'habcdef12, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 5'b10101, 32'h00000000, 1'b0, 32'h12ff56ff, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 5'b10101, 32'h00000000, 1'b0, 32'h12ff56ff, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 4'h0, 5'b10101, 32'h00000000, 1'b0, 32'h12ff56ff, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 4'hF, 5'b10101, 32'h00000000, 1'b0, 32'h12ff56ff, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 4'h0, 5'b01010, 32'h00000000, 1'b0, 32'habcdef12, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 4'h0, 5'b00000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0};

        rst = 1'b1; ena = 1'b0; wena = 1'b0; be = 4'h0; addr = 5'h0;
        data_in = 32'h0; clr_req = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_data_out", data_out, 32'h0);
        check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // initial clear must last exactly DEPTH cycles
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 4'h0, 5'h0, 32'h0, 1'b0);
            n++;
        end while (busy === 1'b1 && n < 100);
        check("init_clear_len", n, 32'd32);

        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b1, 1'b0, 4'($urandom), 5'(a), 32'h0, 1'b0);
            check("zero_after_clear", data_out, 32'h0);
        end

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].e, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, vecs[i].c);
            check($sformatf("vec%0d_data_out", i), data_out, vecs[i].xd);
            check($sformatf("vec%0d_rd_valid", i), {31'h0, rd_valid}, {31'h0, vecs[i].xv});
            check($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].xb});
        end

        // clr_req beats a same-cycle write; a write during busy and a repeat clr_req are ignored
        cycle(1'b1, 1'b1, 4'hF, 5'b01011, 32'h11111111, 1'b1);
        check("clr_busy_rise", {31'h0, busy}, 32'h1);
        n = 0;
        do begin
            cycle(n == 0, n == 0, 4'hF, 5'b01010, 32'h55555555, n == 5);
            n++;
        end while (busy === 1'b1 && n < 100);
        check("req_clear_len", n, 32'd32);
        cycle(1'b1, 1'b0, 4'h0, 5'b01010, 32'h0, 1'b0);
        check("cleared_0a", data_out, 32'h0);
        cycle(1'b1, 1'b0, 4'h0, 5'b01011, 32'h0, 1'b0);
        check("dropped_0b", data_out, 32'h0);

        // reset in the middle of a clear restarts it from address 0
        cycle(1'b1, 1'b1, 4'hF, 5'd3, 32'h00000077, 1'b0);
        cycle(1'b1, 1'b0, 4'h0, 5'd3, 32'h0, 1'b0);
        check("pre_rst_read", data_out, 32'h00000077);
        cycle(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 4'h0, 5'h0, 32'h0, 1'b0);
            n++;
        end while (busy === 1'b1 && n < 100);
        check("rst_clear_len", n, 32'd32);
        cycle(1'b1, 1'b0, 4'h0, 5'd3, 32'h0, 1'b0);
        check("rst_cleared_3", data_out, 32'h0);

`ifdef RAM_BWE_PARITY_EN
        cycle(1'b1, 1'b1, 4'hF, 5'd7, 32'h0f1e2d3c, 1'b0);
        cycle(1'b1, 1'b1, 4'hF, 5'd8, 32'h8899aabb, 1'b0);
        dut.mem_r[7][17] = ~dut.mem_r[7][17];
        m_mem[7][17] = ~m_mem[7][17];
        flip_addr = 7;
        cycle(1'b1, 1'b0, 4'h0, 5'd7, 32'h0, 1'b0);
        check("perr_flipped", {31'h0, parity_err}, 32'h1);
        check("perr_flipped_rv", {31'h0, rd_valid}, 32'h1);
        cycle(1'b1, 1'b0, 4'h0, 5'd8, 32'h0, 1'b0);
        check("perr_clean", {31'h0, parity_err}, 32'h0);
        flip_addr = -1;
        cycle(1'b1, 1'b1, 4'hF, 5'd7, 32'h0, 1'b0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, $urandom % 2 == 1, 4'($urandom), 5'($urandom),
                  $urandom, ($urandom % 120) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
